pc_fetch_unit: RTL and testbench

// - Program-counter / fetch sequencer directly upstream of InstructionMem: owns the PC register and drives pc to InstructionMem.address.
// - Selects next PC (sequential, branch, jump), traps misaligned targets to TRAP_VECTOR, supports ebreak halt/resume.
// - Keeps cycle and retired-instruction counters for the single-cycle core.

---
 rtl/pc_fetch_unit_pkg.sv | 28 ++
 rtl/pc_fetch_unit_perf_counter.sv | 28 ++
 rtl/pc_fetch_unit.sv | 135 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// pc_fetch_unit_pkg : shared constants, state and trap-cause codes for fetch
// Revision: 1.0
// ============================================================================
package pc_fetch_unit_pkg;

    localparam int          XLEN_DEF         = 32;
    localparam int          CNT_WIDTH_DEF    = 64;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;

    // Instructions are word-aligned; any nonzero low bit pair faults.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_perf_counter.sv
`default_nettype none
// ============================================================================
// perf_counter : free-running wrap-around event counter with async reset
// Revision: 1.0
// ============================================================================
module perf_counter #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// pc_fetch_unit : PC register, next-PC selection, misaligned-target trap,
//                 ebreak halt/resume and cycle/instret counters
// Revision: 1.0
// ============================================================================
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int               XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = TRAP_VECTOR_DEF,
    parameter int               CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 branchTaken,
    input  logic [XLEN-1:0]      branchTarget,
    input  logic                 jump,
    input  logic [XLEN-1:0]      jumpTarget,
    input  logic                 haltReq,
    input  logic                 resume,
    output logic [XLEN-1:0]      pc,
    output logic [XLEN-1:0]      pcPlus4,
    output logic                 fetchValid,
    output logic                 trapValid,
    output logic [3:0]           trapCause,
    output logic [XLEN-1:0]      epc,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycleCount,
    output logic [CNT_WIDTH-1:0] instretCount
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [3:0]      cause_q, cause_d;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_tgt;
    logic            redirect;
    logic            retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        epc_d        = epc_q;
        cause_d      = cause_q;
        retire       = 1'b0;
        pc_plus4     = pc_q + PC_STEP;
        redirect     = jump | branchTaken;
        // Jump wins over branch; jalr-style targets drop bit 0 before the check.
        redirect_tgt = jump ? {jumpTarget[XLEN-1:1], 1'b0} : branchTarget;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    if (haltReq) begin
                        state_d = ST_HALT;
                        retire  = 1'b1;
                    end else if (redirect) begin
                        if (is_misaligned(redirect_tgt[1:0])) begin
                            state_d = ST_TRAP;
                            epc_d   = pc_q;
                            pc_d    = TRAP_VECTOR;
                            cause_d = CAUSE_INSTR_MISALIGNED;
                        end else begin
                            pc_d   = redirect_tgt;
                            retire = 1'b1;
                        end
                    end else begin
                        pc_d   = pc_plus4;
                        retire = 1'b1;
                    end
                end
            end
            ST_TRAP: begin
                state_d = ST_RUN;
            end
            ST_HALT: begin
                // Resume steps over the ebreak that caused the halt.
                if (resume) begin
                    state_d = ST_RUN;
                    pc_d    = pc_plus4;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (1'b1),
        .count (cycleCount)
    );

    perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_instret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .count (instretCount)
    );

    assign pc         = pc_q;
    assign pcPlus4    = pc_plus4;
    assign fetchValid = (state_q == ST_RUN);
    assign trapValid  = (state_q == ST_TRAP);
    assign halted     = (state_q == ST_HALT);
    assign trapCause  = cause_q;
    assign epc        = epc_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_pc_fetch_unit : scoreboard bench for pc_fetch_unit
// Revision: 1.0
// ============================================================================
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, branchTaken = 1'b0, jump = 1'b0;
    logic        haltReq = 1'b0, resume = 1'b0;
    logic [31:0] branchTarget = '0, jumpTarget = '0;
    logic [31:0] pc, pcPlus4, epc;
    logic        fetchValid, trapValid, halted;
    logic [3:0]  trapCause;
    logic [63:0] cycleCount, instretCount;

    pc_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branchTaken(branchTaken), .branchTarget(branchTarget),
        .jump(jump), .jumpTarget(jumpTarget),
        .haltReq(haltReq), .resume(resume),
        .pc(pc), .pcPlus4(pcPlus4), .fetchValid(fetchValid),
        .trapValid(trapValid), .trapCause(trapCause), .epc(epc),
        .halted(halted), .cycleCount(cycleCount), .instretCount(instretCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic        fv;
        logic        tv;
        logic        hl;
        logic [3:0]  cause;
        logic [31:0] epc;
        logic [63:0] cyc;
        logic [63:0] ret;
    } obs_t;

    obs_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: 0=BOOT 1=RUN 2=TRAP 3=HALT
    int          m_st;
    logic [31:0] m_pc, m_epc;
    logic [3:0]  m_cause;
    logic [63:0] m_cyc, m_ret;

    function automatic obs_t sample();
        obs_t o;
        o.pc = pc; o.pcp4 = pcPlus4; o.fv = fetchValid; o.tv = trapValid;
        o.hl = halted; o.cause = trapCause; o.epc = epc;
        o.cyc = cycleCount; o.ret = instretCount;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.pc = m_pc; o.pcp4 = m_pc + 32'd4;
        o.fv = (m_st == 1); o.tv = (m_st == 2); o.hl = (m_st == 3);
        o.cause = m_cause; o.epc = m_epc; o.cyc = m_cyc; o.ret = m_ret;
        return o;
    endfunction

    task automatic model_reset();
        m_st = 0; m_pc = 32'h0; m_epc = 32'h0; m_cause = 4'd0;
        m_cyc = 64'd0; m_ret = 64'd0;
    endtask

    // Drive one cycle of inputs, advance the model, queue its expectation.
    task automatic cycle(input logic st, input logic br, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt,
                         input logic h, input logic r);
        logic [31:0] tgt;
        stall = st; branchTaken = br; branchTarget = bt;
        jump = j; jumpTarget = jt; haltReq = h; resume = r;
        m_cyc = m_cyc + 64'd1;
        case (m_st)
            0: m_st = 1;
            1: if (!st) begin
                if (h) begin
                    m_st = 3; m_ret = m_ret + 64'd1;
                end else if (j || br) begin
                    tgt = j ? (jt & 32'hFFFF_FFFE) : bt;
                    if (tgt[1:0] != 2'b00) begin
                        m_epc = m_pc; m_pc = 32'h0000_0100; m_cause = 4'd0; m_st = 2;
                    end else begin
                        m_pc = tgt; m_ret = m_ret + 64'd1;
                    end
                end else begin
                    m_pc = m_pc + 32'd4; m_ret = m_ret + 64'd1;
                end
            end
            2: m_st = 1;
            default: if (r) begin
                m_st = 1; m_pc = m_pc + 32'd4;
            end
        endcase
        sb.push_back(model_obs());
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t act, exp;
        model_reset();
        #12;
        act = sample(); exp = model_obs();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", act, exp);
        end
        rst_n = 1'b1;
        #2;
        act = sample();
        checks++;
        if (act.fv !== 1'b0 || act.pc !== 32'h0 || act.cyc !== 64'd0) begin
            failures++;
            $display("FAIL boot_state fv=%b pc=%h cyc=%0d exp fv=0 pc=0 cyc=0", act.fv, act.pc, act.cyc);
        end
        @(posedge clk); #1;
        // Bring the model into line with the one edge just taken in BOOT.
        m_st = 1; m_cyc = 64'd1;
        act = sample(); exp = model_obs();
        checks++;
        if (act !== exp || act.fv !== 1'b1 || act.pc !== 32'h0) begin
            failures++;
            $display("FAIL boot_exit got=%h exp=%h", act, exp);
        end
    endtask

    task automatic test_sequential();
        obs_t act, exp;
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h4, 32'h8, 32'hC, 32'h10};
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0);
            exp = sb.pop_front(); act = sample();
            checks++;
            if (act !== exp || act.pc !== exp_pc[i]) begin
                failures++;
                $display("FAIL seq[%0d] got=%h exp=%h pc_req=%h", i, act, exp, exp_pc[i]);
            end
        end
        checks++;
        if (instretCount !== 64'd4) begin
            failures++;
            $display("FAIL seq_instret got=%0d exp=4", instretCount);
        end
    endtask

    task automatic test_branch_jump();
        obs_t act, exp;
        cycle(0, 1, 32'h40, 0, 0, 0, 0);
        exp = sb.pop_front(); act = sample();
        checks++;
        if (act !== exp || act.pc !== 32'h40) begin
            failures++;
            $display("FAIL branch got=%h exp=%h", act, exp);
        end
        cycle(0, 1, 32'h40, 1, 32'h80, 0, 0);
        exp = sb.pop_front(); act = sample();
        checks++;
        if (act !== exp || act.pc !== 32'h80) begin
            failures++;
            $display("FAIL jump_priority got=%h exp=%h", act, exp);
        end
    endtask

    task automatic test_misaligned();
        obs_t act, exp;
        logic [63:0] ret0;
        cycle(0, 0, 0, 1, 32'h20, 0, 0);
        exp = sb.pop_front(); act = sample();
        ret0 = act.ret;
        checks++;
        if (act !== exp || act.pc !== 32'h20) begin
            failures++;
            $display("FAIL mis_setup got=%h exp=%h", act, exp);
        end
        cycle(0, 0, 0, 1, 32'h6, 0, 0);
        exp = sb.pop_front(); act = sample();
        checks++;
        if (act !== exp || act.tv !== 1'b1 || act.fv !== 1'b0 || act.epc !== 32'h20 ||
            act.pc !== 32'h100 || act.cause !== 4'd0 || act.ret !== ret0) begin
            failures++;
            $display("FAIL jump_trap got=%h exp=%h", act, exp);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        exp = sb.pop_front(); act = sample();
        checks++;
        if (act !== exp || act.tv !== 1'b0 || act.fv !== 1'b1) begin
            failures++;
            $display("FAIL trap_pulse got=%h exp=%h", act, exp);
        end
        cycle(0, 1, 32'h42, 0, 0, 0, 0);
        exp = sb.pop_front(); act = sample();
        checks++;
        if (act !== exp || act.tv !== 1'b1 || act.epc !== 32'h100) begin
            failures++;
            $display("FAIL branch_trap got=%h exp=%h", act, exp);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        void'(sb.pop_front());
        cycle(0, 0, 0, 1, 32'h201, 0, 0);
        exp = sb.pop_front(); act = sample();
        checks++;
        if (act !== exp || act.pc !== 32'h200 || act.tv !== 1'b0) begin
            failures++;
            $display("FAIL jump_bit0 got=%h exp=%h", act, exp);
        end
    endtask

    task automatic test_stall();
        obs_t act, exp;
        logic [63:0] c0, r0;
        cycle(0, 0, 0, 1, 32'h30, 0, 0);
        void'(sb.pop_front());
        c0 = cycleCount; r0 = instretCount;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 32'h40, 0, 0, 0, 0);
            exp = sb.pop_front(); act = sample();
            checks++;
            if (act !== exp || act.pc !== 32'h30 || act.ret !== r0) begin
                failures++;
                $display("FAIL stall[%0d] got=%h exp=%h", i, act, exp);
            end
        end
        checks++;
        if (cycleCount !== c0 + 64'd3) begin
            failures++;
            $display("FAIL stall_cycles got=%0d exp=%0d", cycleCount, c0 + 64'd3);
        end
    endtask

    task automatic test_halt();
        obs_t act, exp;
        cycle(0, 0, 0, 1, 32'h44, 0, 0);
        void'(sb.pop_front());
        cycle(0, 0, 0, 1, 32'h80, 1, 0);
        exp = sb.pop_front(); act = sample();
        checks++;
        if (act !== exp || act.hl !== 1'b1 || act.pc !== 32'h44 || act.fv !== 1'b0) begin
            failures++;
            $display("FAIL halt_enter got=%h exp=%h", act, exp);
        end
        for (int i = 0; i < 10; i++) begin
            cycle(i[0], 1, 32'h40, 1, 32'h80, 0, 0);
            exp = sb.pop_front(); act = sample();
            checks++;
            if (act !== exp || act.pc !== 32'h44 || act.hl !== 1'b1) begin
                failures++;
                $display("FAIL halt_hold[%0d] got=%h exp=%h", i, act, exp);
            end
        end
        cycle(1, 0, 0, 0, 0, 0, 1);
        exp = sb.pop_front(); act = sample();
        checks++;
        if (act !== exp || act.pc !== 32'h48 || act.fv !== 1'b1 || act.hl !== 1'b0) begin
            failures++;
            $display("FAIL resume got=%h exp=%h", act, exp);
        end
    endtask

    task automatic test_wrap();
        obs_t act, exp;
        cycle(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        exp = sb.pop_front(); act = sample();
        checks++;
        if (act !== exp || act.pcp4 !== 32'h0) begin
            failures++;
            $display("FAIL wrap_link got=%h exp=%h", act, exp);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
        exp = sb.pop_front(); act = sample();
        checks++;
        if (act !== exp || act.pc !== 32'h0) begin
            failures++;
            $display("FAIL wrap_pc got=%h exp=%h", act, exp);
        end
    endtask

    task automatic test_random();
        obs_t act, exp;
        logic [31:0] bt, jt;
        for (int i = 0; i < 200; i++) begin
            bt = $urandom; jt = $urandom;
            if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) jt[1] = 1'b0;
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 3, bt,
                  $urandom_range(0, 9) < 2, jt, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 3);
            exp = sb.pop_front(); act = sample();
            checks++;
            if (act !== exp) begin
                failures++;
                $display("FAIL random[%0d] got=%h exp=%h", i, act, exp);
            end
        end
    endtask

    task automatic test_reset_midrun();
        obs_t act, exp;
        cycle(0, 0, 0, 0, 0, 0, 0);
        void'(sb.pop_front());
        jump = 1'b1; jumpTarget = 32'h80;
        rst_n = 1'b0;
        #2;
        act = sample();
        checks++;
        if (act.pc !== 32'h0 || act.cyc !== 64'd0 || act.ret !== 64'd0 || act.fv !== 1'b0 ||
            act.epc !== 32'h0 || act.hl !== 1'b0 || act.tv !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got=%h exp pc=0 counters=0", act);
        end
        model_reset();
        @(posedge clk); #1;
        jump = 1'b0; jumpTarget = '0;
        rst_n = 1'b1;
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            exp = sb.pop_front();
            if (i == 1) begin
                act = sample();
                checks++;
                if (act !== exp || act.pc !== 32'h4) begin
                    failures++;
                    $display("FAIL post_reset got=%h exp=%h", act, exp);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch_jump();
        test_misaligned();
        test_stall();
        test_halt();
        test_wrap();
        test_random();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
